ucsbece154b_mpfifo: RTL and testbench
=====================================

# ucsbece154b_mpfifo

Multi-port circular FIFO with up to PUSH_PORTS writes and POP_PORTS reads per cycle, arbitrary (non-power-of-two) depth, occupancy/free-slot outputs and synchronous flush. It succeeds the single-port FIFO as the fetch/decode buffer for the dual-issue front end. The fetch stage pushes a bundle of instructions and decode pops a variable number. Flush is driven on branch mispredict.

## Interface
- DATA_WIDTH, 32: width of one entry.
- NR_ENTRIES, 8: depth; any value ≥ 2, not required to be a power of two.
- PUSH_PORTS, 2: maximum entries pushed per cycle; 1..NR_ENTRIES.
- POP_PORTS, 2: maximum entries popped per cycle; 1..NR_ENTRIES.
- CW = $clog2(NR_ENTRIES+1), PW = $clog2(PUSH_PORTS+1), QW = $clog2(POP_PORTS+1): derived local widths.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous clear; highest priority.
- data_i  in  PUSH_PORTS×DATA_WIDTH  push lanes; lane 0 is the oldest.
- push_cnt_i  in  PW  number of lanes to push, taken from lane 0 upward.
- data_o  out  POP_PORTS×DATA_WIDTH  lane k = entry head+k (mod NR_ENTRIES).
- valid_o  out  POP_PORTS  bit k = (count > k).
- pop_cnt_i  in  QW  number of entries to pop, taken from lane 0 upward.
- count_o  out  CW  current occupancy.
- free_o  out  CW  NR_ENTRIES − count.
- full_o  out  1  count == NR_ENTRIES.
- overflow_o  out  1  the push was rejected this cycle (combinational).
- underflow_o  out  1  pop_cnt_i > count this cycle (combinational).

## Operation
- State: head_q, tail_q in [0, NR_ENTRIES−1]; count_q in [0, NR_ENTRIES]. Storage array is not reset.
- Effective pop pop_acc = min(pop_cnt_i, count_q). underflow_o = (pop_cnt_i > count_q). No other effect.
- Push is all-or-nothing. It is accepted iff push_cnt_i ≤ free_q + pop_acc, so same-cycle pop on a full FIFO frees space. Otherwise push_acc = 0 and overflow_o = 1.
- Writes: lane j < push_acc writes to mem[(tail_q + j) mod NR_ENTRIES].
- Next state: head += pop_acc, tail += push_acc, both modulo NR_ENTRIES. count_d = count_q − pop_acc + push_acc.
- Modulo arithmetic uses a subtract-if-≥ compare, never bit truncation. Intermediate sums are CW+1 bits wide.
- flush_i = 1: head, tail and count go to 0 next cycle. Push and pop are ignored, no memory write occurs, and overflow_o / underflow_o are forced to 0.
- data_o is first-word-fall-through: a combinational read at head_q+k. data_o content is don't-care when the matching valid_o bit is 0.
- Flags (full_o, valid_o, free_o) derive combinationally from count_q only. They are never stored separately.

## Timing
- Reset values: head = tail = count = 0; valid_o = 0; full_o = 0; free_o = NR_ENTRIES; overflow_o = underflow_o = 0 (assuming inputs are idle).
- rst_i asserted mid-operation clears state immediately, without waiting for a clock edge. Contents are lost logically and mem is unchanged.
- Push-to-visible latency: 1 cycle. Data pushed at edge n appears on data_o / valid_o after edge n.
- Pop takes effect at the edge. The lanes consumed are the ones shown on data_o during that cycle.
- overflow_o / underflow_o depend combinationally on push_cnt_i, pop_cnt_i and count_q, with no register stage.
- Wrap-around: a multi-lane push or pop that straddles index NR_ENTRIES−1 continues at index 0 in the same cycle.

## Structure
- Package ucsbece154b_fifo_pkg holds:
  - function wrap_add(ptr, inc, depth) returning (ptr+inc) mod depth;
  - function clog2p1 for the derived widths.
- Sub-module ucsbece154b_fifo_ctrl holds the pointers, count, accept logic and flags. The top level holds the storage array, write decode and read muxes.

## Test plan
Configuration for all tests: NR_ENTRIES=6, PUSH_PORTS=2, POP_PORTS=2, DATA_WIDTH=32.

- Reset, then idle: count_o=0, free_o=6, valid_o=2'b00, full_o=0.
- Push 2 lanes (0xA, 0xB) for 3 cycles (0xA..0xF): full_o=1, count_o=6, data_o={0xB, 0xA}, valid_o=2'b11.
- Full FIFO, push_cnt=2 (0x10, 0x11) with pop_cnt=2: no overflow_o. count stays 6. Next cycle data_o={0xD, 0xC}.
- Full FIFO, push_cnt=1 with pop_cnt=0: overflow_o=1, count stays 6, contents unchanged.
- Wrap: starting from head=5, count=1, push 2 (0x20, 0x21), pop 1. Next cycle data_o lane0=0x20 (index 0), lane1=0x21, count=2.
- Count=1, pop_cnt=2: underflow_o=1, count becomes 0. Then assert flush_i together with push_cnt=2: count stays 0, overflow_o=0. Assert rst_i async mid-cycle: valid_o=0 before the next edge.

Source files
------------

// File: rtl/ucsbece154b_fifo_pkg.sv
// Shared helpers for the multi-port FIFO.
//   clog2p1  : bits needed to hold the values 0..n
//   wrap_add : (ptr + inc) mod depth, for ptr < depth and inc <= depth
package ucsbece154b_fifo_pkg;

    function automatic int unsigned clog2p1(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // One conditional subtract is enough because both operands are already bounded by depth.
    function automatic int unsigned wrap_add(input int unsigned ptr,
                                             input int unsigned inc,
                                             input int unsigned depth);
        int unsigned sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/ucsbece154b_fifo_ctrl.sv
// Pointer / occupancy controller for the multi-port FIFO.
//   clk_i, rst_i           : clock, async active-high reset
//   flush                  : synchronous clear, overrides push and pop
//   push_cnt, pop_cnt      : requested lanes this cycle
//   head, tail, count      : registered state
//   free, full, valid      : flags decoded from count
//   push_acc_c             : lanes actually written this cycle
//   overflow_c, underflow_c: rejected push / over-long pop this cycle
module ucsbece154b_fifo_ctrl
    import ucsbece154b_fifo_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 8,
    parameter int unsigned PUSH_PORTS = 2,
    parameter int unsigned POP_PORTS  = 2,
    localparam int unsigned CW = clog2p1(NR_ENTRIES),
    localparam int unsigned PW = clog2p1(PUSH_PORTS),
    localparam int unsigned QW = clog2p1(POP_PORTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush,
    input  logic [PW-1:0]        push_cnt,
    input  logic [QW-1:0]        pop_cnt,
    output logic [CW-1:0]        head,
    output logic [CW-1:0]        tail,
    output logic [CW-1:0]        count,
    output logic [CW-1:0]        free,
    output logic                 full,
    output logic [POP_PORTS-1:0] valid,
    output logic [PW-1:0]        push_acc_c,
    output logic                 overflow_c,
    output logic                 underflow_c
);

    localparam int unsigned XW = CW + 1;
    localparam logic [XW-1:0] DEPTH = XW'(NR_ENTRIES);

    logic [CW-1:0] head_q, tail_q, count_q;
    logic [XW-1:0] cnt_x, pop_req_x, push_req_x, pop_acc_x, push_acc_x, room_x;
    logic [XW-1:0] head_d, tail_d, count_d;
    logic          accept;

    // Accept logic and next-state arithmetic, all in CW+1 bits.
    always_comb begin
        cnt_x       = XW'(count_q);
        pop_req_x   = XW'(pop_cnt);
        push_req_x  = XW'(push_cnt);
        overflow_c  = 1'b0;
        underflow_c = 1'b0;

        pop_acc_x  = (pop_req_x > cnt_x) ? cnt_x : pop_req_x;
        // Space freed by this cycle's pop counts toward the push.
        room_x     = DEPTH - cnt_x + pop_acc_x;
        accept     = (push_req_x <= room_x);
        push_acc_x = accept ? push_req_x : '0;

        if (flush) begin
            pop_acc_x  = '0;
            push_acc_x = '0;
        end else begin
            underflow_c = (pop_req_x > cnt_x);
            overflow_c  = !accept;
        end

        head_d = XW'(head_q) + pop_acc_x;
        if (head_d >= DEPTH) begin
            head_d = head_d - DEPTH;
        end
        tail_d = XW'(tail_q) + push_acc_x;
        if (tail_d >= DEPTH) begin
            tail_d = tail_d - DEPTH;
        end
        count_d = cnt_x - pop_acc_x + push_acc_x;

        push_acc_c = PW'(push_acc_x);
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= CW'(head_d);
            tail_q  <= CW'(tail_d);
            count_q <= CW'(count_d);
        end
    end

    // Flags are pure decodes of count_q.
    always_comb begin
        free  = CW'(DEPTH - cnt_x);
        full  = (count_q == CW'(NR_ENTRIES));
        valid = '0;
        for (int k = 0; k < POP_PORTS; k++) begin
            valid[k] = (count_q > CW'(k));
        end
    end

    assign head  = head_q;
    assign tail  = tail_q;
    assign count = count_q;

endmodule

// File: rtl/ucsbece154b_mpfifo.sv
// Multi-port circular FIFO (fetch/decode buffer), first-word-fall-through.
//   clk_i, rst_i, flush_i         : clock, async active-high reset, sync clear
//   data_i, push_cnt_i            : push lanes (lane 0 oldest) and lane count
//   data_o, valid_o, pop_cnt_i    : read lanes from head, their valid bits, pop count
//   count_o, free_o, full_o       : occupancy flags
//   overflow_o, underflow_o       : combinational reject / over-pop indicators
module ucsbece154b_mpfifo
    import ucsbece154b_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NR_ENTRIES = 8,
    parameter int unsigned PUSH_PORTS = 2,
    parameter int unsigned POP_PORTS  = 2,
    localparam int unsigned CW = clog2p1(NR_ENTRIES),
    localparam int unsigned PW = clog2p1(PUSH_PORTS),
    localparam int unsigned QW = clog2p1(POP_PORTS)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic [PUSH_PORTS*DATA_WIDTH-1:0] data_i,
    input  logic [PW-1:0]                    push_cnt_i,
    output logic [POP_PORTS*DATA_WIDTH-1:0]  data_o,
    output logic [POP_PORTS-1:0]             valid_o,
    input  logic [QW-1:0]                    pop_cnt_i,
    output logic [CW-1:0]                    count_o,
    output logic [CW-1:0]                    free_o,
    output logic                             full_o,
    output logic                             overflow_o,
    output logic                             underflow_o
);

    localparam int unsigned AW = $clog2(NR_ENTRIES);

    logic [DATA_WIDTH-1:0] mem [NR_ENTRIES];
    logic [CW-1:0]         head, tail;
    logic [PW-1:0]         push_acc;
    logic [AW-1:0]         wr_addr [PUSH_PORTS];

    ucsbece154b_fifo_ctrl #(
        .NR_ENTRIES (NR_ENTRIES),
        .PUSH_PORTS (PUSH_PORTS),
        .POP_PORTS  (POP_PORTS)
    ) u_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush       (flush_i),
        .push_cnt    (push_cnt_i),
        .pop_cnt     (pop_cnt_i),
        .head        (head),
        .tail        (tail),
        .count       (count_o),
        .free        (free_o),
        .full        (full_o),
        .valid       (valid_o),
        .push_acc_c  (push_acc),
        .overflow_c  (overflow_o),
        .underflow_c (underflow_o)
    );

    // Write lanes land at consecutive slots from tail, wrapping past the last index.
    always_comb begin
        for (int j = 0; j < PUSH_PORTS; j++) begin
            wr_addr[j] = AW'(wrap_add(32'(tail), j, NR_ENTRIES));
        end
    end

    // Storage is not reset; push_acc is zero on flush or reject.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < PUSH_PORTS; j++) begin
            if (PW'(j) < push_acc) begin
                mem[wr_addr[j]] <= data_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Fall-through read lanes starting at head.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < POP_PORTS; k++) begin
            data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem[AW'(wrap_add(32'(head), k, NR_ENTRIES))];
        end
    end

endmodule

// File: tb/tb_ucsbece154b_mpfifo.sv
// Directed bench for ucsbece154b_mpfifo with NR_ENTRIES=6, two push and two pop lanes.
module tb_ucsbece154b_mpfifo;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [63:0] data_i = '0;
    logic [1:0]  push_cnt_i = '0;
    logic [63:0] data_o;
    logic [1:0]  valid_o;
    logic [1:0]  pop_cnt_i = '0;
    logic [2:0]  count_o;
    logic [2:0]  free_o;
    logic        full_o;
    logic        overflow_o;
    logic        underflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    ucsbece154b_mpfifo #(
        .DATA_WIDTH (32),
        .NR_ENTRIES (6),
        .PUSH_PORTS (2),
        .POP_PORTS  (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .data_i      (data_i),
        .push_cnt_i  (push_cnt_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .pop_cnt_i   (pop_cnt_i),
        .count_o     (count_o),
        .free_o      (free_o),
        .full_o      (full_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] pc, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] qc, input logic fl);
        push_cnt_i = pc;
        data_i     = {d1, d0};
        pop_cnt_i  = qc;
        flush_i    = fl;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0);
    endtask

    task automatic check_occ(input string tag, input logic [2:0] cnt, input logic [1:0] vld);
        check({tag, "_count"}, 64'(count_o), 64'(cnt));
        check({tag, "_valid"}, 64'(valid_o), 64'(vld));
    endtask

    task automatic check_lanes(input string tag, input logic [31:0] l0, input logic [31:0] l1);
        check({tag, "_lane0"}, 64'(data_o[31:0]), 64'(l0));
        check({tag, "_lane1"}, 64'(data_o[63:32]), 64'(l1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held, idle inputs.
        #12;
        check_occ("rst", 3'd0, 2'b00);
        check("rst_free", 64'(free_o), 64'd6);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_unf", 64'(underflow_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_occ("idle", 3'd0, 2'b00);
        check("idle_free", 64'(free_o), 64'd6);

        // Fill with 0xA..0xF.
        drive(2'd2, 32'hA, 32'hB, 2'd0, 1'b0); tick();
        check_occ("fill1", 3'd2, 2'b11);
        check_lanes("fill1", 32'hA, 32'hB);
        drive(2'd2, 32'hC, 32'hD, 2'd0, 1'b0); tick();
        drive(2'd2, 32'hE, 32'hF, 2'd0, 1'b0); tick();
        check_occ("full", 3'd6, 2'b11);
        check("full_flag", 64'(full_o), 64'd1);
        check("full_free", 64'(free_o), 64'd0);
        check_lanes("full", 32'hA, 32'hB);

        // Push 2 + pop 2 on a full FIFO is accepted.
        drive(2'd2, 32'h10, 32'h11, 2'd2, 1'b0);
        #1;
        check("pp_ovf", 64'(overflow_o), 64'd0);
        check("pp_unf", 64'(underflow_o), 64'd0);
        tick();
        check_occ("pp", 3'd6, 2'b11);
        check_lanes("pp", 32'hC, 32'hD);

        // Push 1 with no pop on a full FIFO is rejected.
        drive(2'd1, 32'h99, 32'h0, 2'd0, 1'b0);
        #1;
        check("ovf_flag", 64'(overflow_o), 64'd1);
        check("ovf_unf", 64'(underflow_o), 64'd0);
        tick();
        check_occ("ovf", 3'd6, 2'b11);
        check_lanes("ovf", 32'hC, 32'hD);

        // Pop 2 then 1; the second leaves head at 5 so lane 1 reads index 0 (0x10).
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0); tick();
        check_occ("pop2", 3'd4, 2'b11);
        check_lanes("pop2", 32'hE, 32'hF);
        drive(2'd0, 32'h0, 32'h0, 2'd1, 1'b0); tick();
        check_occ("rdwrap", 3'd3, 2'b11);
        check_lanes("rdwrap", 32'hF, 32'h10);

        // Flush beats a simultaneous push.
        drive(2'd2, 32'h77, 32'h78, 2'd0, 1'b1);
        #1;
        check("fl1_ovf", 64'(overflow_o), 64'd0);
        tick();
        check_occ("fl1", 3'd0, 2'b00);
        check("fl1_free", 64'(free_o), 64'd6);

        // Reach head=5, count=1: fill 0x30..0x35, pop 5.
        drive(2'd2, 32'h30, 32'h31, 2'd0, 1'b0); tick();
        drive(2'd2, 32'h32, 32'h33, 2'd0, 1'b0); tick();
        drive(2'd2, 32'h34, 32'h35, 2'd0, 1'b0); tick();
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0); tick();
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0); tick();
        drive(2'd0, 32'h0, 32'h0, 2'd1, 1'b0); tick();
        check_occ("h5", 3'd1, 2'b01);
        check("h5_lane0", 64'(data_o[31:0]), 64'h35);

        // Push 2 + pop 1 with head wrapping to 0.
        drive(2'd2, 32'h20, 32'h21, 2'd1, 1'b0);
        #1;
        check("wrap_ovf", 64'(overflow_o), 64'd0);
        tick();
        check_occ("wrap", 3'd2, 2'b11);
        check_lanes("wrap", 32'h20, 32'h21);

        // Count 1 then pop 2: underflow, count clamps to 0.
        drive(2'd0, 32'h0, 32'h0, 2'd1, 1'b0); tick();
        check_occ("c1", 3'd1, 2'b01);
        check("c1_lane0", 64'(data_o[31:0]), 64'h21);
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0);
        #1;
        check("unf_flag", 64'(underflow_o), 64'd1);
        check("unf_ovf", 64'(overflow_o), 64'd0);
        tick();
        check_occ("unf", 3'd0, 2'b00);

        // Move tail to 5, then a 2-lane push straddles indices 5 and 0.
        drive(2'd2, 32'h40, 32'h41, 2'd0, 1'b0); tick();
        drive(2'd1, 32'h42, 32'h0, 2'd0, 1'b0); tick();
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0); tick();
        drive(2'd0, 32'h0, 32'h0, 2'd1, 1'b0); tick();
        check_occ("t5", 3'd0, 2'b00);
        drive(2'd2, 32'h50, 32'h51, 2'd0, 1'b0); tick();
        check_occ("wrwrap", 3'd2, 2'b11);
        check_lanes("wrwrap", 32'h50, 32'h51);

        // Flush with push and an over-long pop: both flags forced low.
        drive(2'd2, 32'h60, 32'h61, 2'd3, 1'b1);
        #1;
        check("fl2_ovf", 64'(overflow_o), 64'd0);
        check("fl2_unf", 64'(underflow_o), 64'd0);
        tick();
        check_occ("fl2", 3'd0, 2'b00);

        // Asynchronous reset mid-cycle.
        drive(2'd2, 32'h70, 32'h71, 2'd0, 1'b0); tick();
        check_occ("pre_ar", 3'd2, 2'b11);
        #3;
        rst_i = 1'b1;
        #1;
        check_occ("ar", 3'd0, 2'b00);
        check("ar_free", 64'(free_o), 64'd6);
        check("ar_full", 64'(full_o), 64'd0);
        #2;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_occ("post_ar", 3'd0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
